// File: rtl/regs_dbg_master.sv
// rtl/regs_dbg_master.sv - debug preload/dump initiator for the picoMIPS register file
// Optional DUMP_SKIP_ZERO_EN: dump starts at r1 and loads to r0 are dropped in IDLE.
module regs_dbg_master #(
  parameter int n    = 8,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load,
  input  logic [4:0]   load_addr,
  input  logic [n-1:0] load_data,
  output logic         w,
  output logic [n-1:0] Wdata,
  output logic [4:0]   Rdno,
  output logic [4:0]   Rsno,
  input  logic [n-1:0] Rs,
  output logic [n-1:0] dout,
  output logic [4:0]   dout_addr,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, HOLD, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);
`ifdef DUMP_SKIP_ZERO_EN
  localparam logic [4:0] FIRST_IDX = 5'd1;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

  state_t       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic         w_q, w_d;
  logic [n-1:0] Wdata_q, Wdata_d;
  logic [4:0]   Rdno_q, Rdno_d;
  logic [4:0]   Rsno_q, Rsno_d;
  logic [n-1:0] dout_q, dout_d;
  logic [4:0]   dout_addr_q, dout_addr_d;
  logic         dout_valid_q, dout_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         load_ok;

`ifdef DUMP_SKIP_ZERO_EN
  assign load_ok = (load_addr != 5'd0);
`else
  assign load_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 5'd0;
      w_q          <= 1'b0;
      Wdata_q      <= '0;
      Rdno_q       <= 5'd0;
      Rsno_q       <= 5'd0;
      dout_q       <= '0;
      dout_addr_q  <= 5'd0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      w_q          <= w_d;
      Wdata_q      <= Wdata_d;
      Rdno_q       <= Rdno_d;
      Rsno_q       <= Rsno_d;
      dout_q       <= dout_d;
      dout_addr_q  <= dout_addr_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    w_d          = 1'b0;
    Wdata_d      = Wdata_q;
    Rdno_d       = Rdno_q;
    Rsno_d       = Rsno_q;
    dout_d       = dout_q;
    dout_addr_d  = dout_addr_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // load has priority; a simultaneous start is dropped, not queued
        if (load) begin
          if (load_ok) begin
            state_d = WRITE;
            Wdata_d = load_data;
            Rdno_d  = load_addr;
            w_d     = (load_addr != 5'd0);
          end
        end else if (start) begin
          state_d = READ;
          idx_d   = FIRST_IDX;
          Rsno_d  = FIRST_IDX;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        dout_d       = Rs;
        dout_addr_d  = idx_q;
        dout_valid_d = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            Rsno_d  = idx_q + 5'd1;
            state_d = READ;
          end
        end
      end
      // done is registered out of DONE, so it lands in the first IDLE cycle
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign w          = w_q;
  assign Wdata      = Wdata_q;
  assign Rdno       = Rdno_q;
  assign Rsno       = Rsno_q;
  assign dout       = dout_q;
  assign dout_addr  = dout_addr_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regs_dbg_master.sv
// tb/tb_regs_dbg_master.sv - directed bench for regs_dbg_master with a register file model
module tb_regs_dbg_master;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_addr = 5'd0;
  logic [7:0] load_data = 8'd0;
  logic       w;
  logic [7:0] Wdata;
  logic [4:0] Rdno;
  logic [4:0] Rsno;
  logic [7:0] Rs;
  logic [7:0] dout;
  logic [4:0] dout_addr;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [7:0] rf [32];

`ifdef DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
  localparam int NWORDS = 31;
  localparam int DONE_CYC = 63;
`else
  localparam int FIRST = 0;
  localparam int NWORDS = 32;
  localparam int DONE_CYC = 65;
`endif

  regs_dbg_master #(.n(8), .NREG(32)) dut (
    .clk(clk), .reset(reset), .start(start), .load(load),
    .load_addr(load_addr), .load_data(load_data),
    .w(w), .Wdata(Wdata), .Rdno(Rdno), .Rsno(Rsno), .Rs(Rs),
    .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w && Rdno != 5'd0) rf[Rdno] <= Wdata;
  assign Rs = (Rsno == 5'd0) ? 8'd0 : rf[Rsno];

  function automatic logic [7:0] exp_data(input int a);
    return (a == 0) ? 8'd0 : 8'(a + 8'h10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] a, input logic [7:0] d);
    load = 1'b1; load_addr = a; load_data = d;
    step();
    load = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({w, Wdata, Rdno, Rsno, dout, dout_addr, dout_valid, busy, done} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {w, Wdata, Rdno, Rsno, dout, dout_addr, dout_valid, busy, done});
    end
  endtask

  task automatic test_preload();
    int whigh = 0;
    load = 1'b1; load_addr = 5'd5; load_data = 8'hA5;
    step();
    load = 1'b0;
    checks++;
    if ({w, busy, Rdno, Wdata} !== {1'b1, 1'b1, 5'd5, 8'hA5}) begin
      errors++;
      $display("FAIL preload_write got w=%b busy=%b Rdno=%0d Wdata=%h want 1 1 5 a5", w, busy, Rdno, Wdata);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (w || busy) whigh++;
    end
    checks++;
    if (whigh != 0) begin
      errors++;
      $display("FAIL preload_single_cycle got %0d extra w/busy cycles want 0", whigh);
    end
    checks++;
    if (rf[5] !== 8'hA5) begin
      errors++;
      $display("FAIL preload_rf got %h want a5", rf[5]);
    end
  endtask

  task automatic test_zero_write();
    int wcnt = 0;
    int bcnt = 0;
    load = 1'b1; load_addr = 5'd0; load_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      load = 1'b0;
      if (w) wcnt++;
      if (busy) bcnt++;
    end
    checks++;
    if (wcnt != 0) begin
      errors++;
      $display("FAIL zero_write_w got %0d cycles want 0", wcnt);
    end
    checks++;
`ifdef DUMP_SKIP_ZERO_EN
    if (bcnt != 0) begin
      errors++;
      $display("FAIL zero_write_busy got %0d want 0", bcnt);
    end
`else
    if (bcnt != 1) begin
      errors++;
      $display("FAIL zero_write_busy got %0d want 1", bcnt);
    end
`endif
    checks++;
    if (Rs !== 8'd0 && Rsno == 5'd0) begin
      errors++;
      $display("FAIL zero_write_r0 got %h want 0", Rs);
    end
  endtask

  task automatic test_full_dump();
    int first_valid = -1;
    int done_at = -1;
    int ndone = 0;
    int nwords = 0;
    int bad = 0;
    for (int k = 1; k < 32; k++) do_load(5'(k), exp_data(k));
    dout_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (dout_valid && dout_ready) begin
        if (dout_addr !== 5'(FIRST + nwords) || dout !== exp_data(FIRST + nwords)) bad++;
        nwords++;
      end
      if (done) begin
        ndone++;
        done_at = cyc;
      end
      step();
    end
    checks++;
    if (first_valid != 1) begin
      errors++;
      $display("FAIL dump_first_valid got %0d want 1", first_valid);
    end
    checks++;
    if (nwords != NWORDS) begin
      errors++;
      $display("FAIL dump_word_count got %0d want %0d", nwords, NWORDS);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dump_word_values got %0d bad words want 0", bad);
    end
    checks++;
    if (ndone != 1 || done_at != DONE_CYC) begin
      errors++;
      $display("FAIL dump_done got count=%0d at=%0d want 1 at %0d", ndone, done_at, DONE_CYC);
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    int ndone = 0;
    int unstable = 0;
    logic [7:0] held;
    dout_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!(dout_valid && dout_addr == 5'd7) && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL bp_reach_addr7 got timeout want word 7");
    end
    held = dout;
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!dout_valid || dout !== held || dout_addr !== 5'd7) unstable++;
    end
    checks++;
    if (unstable != 0 || held !== exp_data(7)) begin
      errors++;
      $display("FAIL bp_stable got %0d unstable cycles data=%h want 0 and %h", unstable, held, exp_data(7));
    end
    dout_ready = 1'b1;
    step();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_gap got valid=%b want 0", dout_valid);
    end
    step();
    checks++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 5'd8, exp_data(8)}) begin
      errors++;
      $display("FAIL bp_word8 got v=%b a=%0d d=%h want 1 8 %h", dout_valid, dout_addr, dout, exp_data(8));
    end
    for (int i = 0; i < 80; i++) begin
      if (done) ndone++;
      step();
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL bp_done got %0d want 1", ndone);
    end
  endtask

  task automatic test_start_mid_dump();
    int ndone = 0;
    int done_at = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      start = (cyc == 10 || cyc == 21);
      if (done) begin
        ndone++;
        done_at = cyc;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || done_at != DONE_CYC) begin
      errors++;
      $display("FAIL mid_start_done got count=%0d at=%0d want 1 at %0d", ndone, done_at, DONE_CYC);
    end
  endtask

  task automatic test_collision();
    int stray = 0;
    load = 1'b1; start = 1'b1; load_addr = 5'd3; load_data = 8'h33;
    step();
    load = 1'b0; start = 1'b0;
    checks++;
    if ({w, busy, Rdno, Wdata} !== {1'b1, 1'b1, 5'd3, 8'h33}) begin
      errors++;
      $display("FAIL collision_write got w=%b busy=%b Rdno=%0d Wdata=%h want 1 1 3 33", w, busy, Rdno, Wdata);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy || dout_valid || done) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL collision_no_dump got %0d busy cycles want 0", stray);
    end
    do_load(5'd3, exp_data(3));
  endtask

  task automatic test_reset_mid_dump();
    int guard = 0;
    int stray = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!(dout_valid && dout_addr == 5'd12) && guard < 100) begin
      step();
      guard++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({w, Wdata, Rdno, Rsno, dout, dout_addr, dout_valid, busy, done} !== 35'd0 || guard >= 100) begin
      errors++;
      $display("FAIL reset_mid_dump got %h guard=%0d want 0",
               {w, Wdata, Rdno, Rsno, dout, dout_addr, dout_valid, busy, done}, guard);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d stray cycles want 0", stray);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 5'(FIRST), exp_data(FIRST)}) begin
      errors++;
      $display("FAIL restart_first got v=%b a=%0d d=%h want 1 %0d %h",
               dout_valid, dout_addr, dout, FIRST, exp_data(FIRST));
    end
    for (int i = 0; i < 80; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 8'd0;
    test_reset();
    test_preload();
    test_zero_write();
    test_full_dump();
    test_backpressure();
    test_start_mid_dump();
    test_collision();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
